// File: rtl/yol_pkg.sv
`default_nettype none
// ============================================================================
// Package : yol_pkg
// Desc    : Shared constants, FSM state type and hop-stack entry layout for
//           the 4-ary tree path decoder.
// Rev     : 1.0 - initial release
// ============================================================================
package yol_pkg;

    // Number of top-level (parentless) nodes: 0, 1 and 2
    localparam int KOK_SAYISI = 3;

    // Fan-out of every node in the tree
    localparam int DAL_SAYISI = 4;

    // Node width the stand-alone adim_t layout is sized for
    localparam int VARSAYILAN_DUGUM_W = 8;

    // Decoder states: idle, walk towards the root, emit hops root-first
    typedef enum logic [1:0] {
        BOS    = 2'd0,
        COZ    = 2'd1,
        GONDER = 2'd2
    } durum_t;

    // One hop: the source node and the branch taken out of it
    typedef struct packed {
        logic [VARSAYILAN_DUGUM_W-1:0] dugum;
        logic [1:0]                    yon;
    } adim_t;

endpackage
`default_nettype wire

// File: rtl/yol_cozucu_ata_hesapla.sv
`default_nettype none
// ============================================================================
// Module : ata_hesapla
// Desc   : Combinational parent step of the 4-ary tree. For a node n >= 3 it
//          returns ata = (n-3) >> 2 and yon = (n-3) & 3; kok flags the
//          top-level nodes 0..2, for which ata and yon are forced to zero.
// Rev    : 1.0 - initial release
// ============================================================================
module ata_hesapla
    import yol_pkg::*;
#(
    parameter int DUGUM_W = 8
) (
    input  logic [DUGUM_W-1:0] n,
    output logic [DUGUM_W-1:0] ata,
    output logic [1:0]         yon,
    output logic               kok
);

    logic [DUGUM_W-1:0] w_fark;

    // Parent and branch; the subtraction is masked for top-level nodes so it
    // can never wrap around
    always_comb begin
        kok    = (n < DUGUM_W'(KOK_SAYISI));
        w_fark = kok ? '0 : (n - DUGUM_W'(KOK_SAYISI));
        ata    = {2'b00, w_fark[DUGUM_W-1:2]};
        yon    = w_fark[1:0];
    end

endmodule
`default_nettype wire

// File: rtl/yol_cozucu.sv
`default_nettype none
// ============================================================================
// Module : yol_cozucu
// Desc   : Path decoder for the 4-ary node tree. Accepts a destination node,
//          walks up to its top-level node one hop per clock while pushing
//          each hop on a LIFO, then streams the hops root-first as
//          (kaynak_dugumu, yon) beats with son on the final beat. A target
//          that is itself a top-level node yields one bos_yol beat.
// Rev    : 1.0 - initial release
// ============================================================================
module yol_cozucu
    import yol_pkg::*;
#(
    parameter int DUGUM_W  = 8,
    parameter int MAX_ADIM = DUGUM_W / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               giris_gecerli,
    output logic               giris_hazir,
    input  logic [DUGUM_W-1:0] hedef_dugumu,
    output logic               cikis_gecerli,
    input  logic               cikis_hazir,
    output logic [DUGUM_W-1:0] kaynak_dugumu,
    output logic [1:0]         yon,
    output logic               son,
    output logic               bos_yol
);

    // Stack pointer counts 0..MAX_ADIM; the entry index covers 0..MAX_ADIM-1
    localparam int SP_W  = $clog2(MAX_ADIM + 1);
    localparam int IDX_W = (MAX_ADIM > 1) ? $clog2(MAX_ADIM) : 1;

    // Same layout as adim_t, but sized by this instance's DUGUM_W
    typedef struct packed {
        logic [DUGUM_W-1:0] dugum;
        logic [1:0]         yon;
    } yigin_t;

    durum_t             r_durum;
    durum_t             w_sonraki_durum;
    logic [DUGUM_W-1:0] r_cur;
    logic [SP_W-1:0]    r_sp;
    logic               r_bos_yol;
    yigin_t             r_yigin [MAX_ADIM];

    logic [DUGUM_W-1:0] w_ata;
    logic [1:0]         w_yon;
    logic               w_kok;
    logic               w_kabul;
    logic               w_hedef_kok;
    logic               w_son_girdi;
    logic [IDX_W-1:0]   w_yaz_idx;
    logic [IDX_W-1:0]   w_oku_idx;
    yigin_t             w_ust;

    ata_hesapla #(
        .DUGUM_W (DUGUM_W)
    ) u_ata_hesapla (
        .n   (r_cur),
        .ata (w_ata),
        .yon (w_yon),
        .kok (w_kok)
    );

    // Handshake, zero-hop detection and stack addressing
    always_comb begin
        w_kabul     = giris_gecerli && (r_durum == BOS);
        w_hedef_kok = (hedef_dugumu < DUGUM_W'(KOK_SAYISI));
        w_son_girdi = (r_sp <= SP_W'(1));
        w_yaz_idx   = IDX_W'(r_sp);
        w_oku_idx   = (r_sp == '0) ? '0 : IDX_W'(r_sp - SP_W'(1));
        w_ust       = r_yigin[w_oku_idx];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum <= BOS;
        end else begin
            r_durum <= w_sonraki_durum;
        end
    end

    // Next-state logic
    always_comb begin
        w_sonraki_durum = r_durum;
        case (r_durum)
            BOS: begin
                if (w_kabul) begin
                    w_sonraki_durum = w_hedef_kok ? GONDER : COZ;
                end
            end
            COZ: begin
                // The hop being pushed now reaches a top-level node
                if (w_kok || (w_ata < DUGUM_W'(KOK_SAYISI))) begin
                    w_sonraki_durum = GONDER;
                end
            end
            GONDER: begin
                if (cikis_hazir && (r_bos_yol || w_son_girdi)) begin
                    w_sonraki_durum = BOS;
                end
            end
            default: begin
                w_sonraki_durum = BOS;
            end
        endcase
    end

    // Current node, stack pointer and zero-hop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur     <= '0;
            r_sp      <= '0;
            r_bos_yol <= 1'b0;
        end else begin
            case (r_durum)
                BOS: begin
                    if (w_kabul) begin
                        r_cur     <= hedef_dugumu;
                        r_sp      <= '0;
                        r_bos_yol <= w_hedef_kok;
                    end
                end
                COZ: begin
                    if (!w_kok) begin
                        r_cur <= w_ata;
                        r_sp  <= r_sp + SP_W'(1);
                    end
                end
                GONDER: begin
                    if (cikis_hazir) begin
                        if (r_bos_yol) begin
                            r_bos_yol <= 1'b0;
                        end else if (r_sp != '0) begin
                            r_sp <= r_sp - SP_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Hop LIFO; contents need no reset because the pointer gates every read
    always_ff @(posedge clk) begin
        if ((r_durum == COZ) && !w_kok) begin
            r_yigin[w_yaz_idx] <= '{dugum: w_ata, yon: w_yon};
        end
    end

    // Output decode; data outputs stay zero whenever no beat is offered
    always_comb begin
        giris_hazir   = 1'b0;
        cikis_gecerli = 1'b0;
        kaynak_dugumu = '0;
        yon           = 2'b00;
        son           = 1'b0;
        bos_yol       = 1'b0;
        case (r_durum)
            BOS: begin
                giris_hazir = 1'b1;
            end
            GONDER: begin
                cikis_gecerli = 1'b1;
                if (r_bos_yol) begin
                    kaynak_dugumu = r_cur;
                    son           = 1'b1;
                    bos_yol       = 1'b1;
                end else begin
                    kaynak_dugumu = w_ust.dugum;
                    yon           = w_ust.yon;
                    son           = (r_sp == SP_W'(1));
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_yol_cozucu.sv
`default_nettype none
// ============================================================================
// Module : tb_yol_cozucu
// Desc   : Self-checking bench for the 4-ary tree path decoder (DUGUM_W = 8).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_yol_cozucu;
    import yol_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          giris_gecerli = 1'b0;
    logic          giris_hazir;
    logic [DW-1:0] hedef_dugumu = '0;
    logic          cikis_gecerli;
    logic          cikis_hazir = 1'b0;
    logic [DW-1:0] kaynak_dugumu;
    logic [1:0]    yon;
    logic          son;
    logic          bos_yol;

    int n_assert = 0;
    int n_fail   = 0;

    yol_cozucu #(
        .DUGUM_W  (DW),
        .MAX_ADIM (DW / 2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .giris_gecerli (giris_gecerli),
        .giris_hazir   (giris_hazir),
        .hedef_dugumu  (hedef_dugumu),
        .cikis_gecerli (cikis_gecerli),
        .cikis_hazir   (cikis_hazir),
        .kaynak_dugumu (kaynak_dugumu),
        .yon           (yon),
        .son           (son),
        .bos_yol       (bos_yol)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] t);
        giris_gecerli = 1'b1;
        hedef_dugumu  = t;
        chk("accept_ready", {31'd0, giris_hazir}, 32'd1);
        tick();
        giris_gecerli = 1'b0;
        hedef_dugumu  = 8'hAA;
    endtask

    task automatic wait_valid(input int lim, output int w);
        w = 0;
        while (!cikis_gecerli && w < lim) begin
            tick();
            w++;
        end
    endtask

    task automatic beat(input string tag, input int k, input int y, input int s, input int b);
        chk({tag, "_valid"}, {31'd0, cikis_gecerli}, 32'd1);
        chk({tag, "_kaynak"}, {24'd0, kaynak_dugumu}, k);
        chk({tag, "_yon"}, {30'd0, yon}, y);
        chk({tag, "_son"}, {31'd0, son}, s);
        chk({tag, "_bos_yol"}, {31'd0, bos_yol}, b);
        tick();
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_valid"}, {31'd0, cikis_gecerli}, 32'd0);
        chk({tag, "_ready"}, {31'd0, giris_hazir}, 32'd1);
        chk({tag, "_kaynak"}, {24'd0, kaynak_dugumu}, 32'd0);
        chk({tag, "_yon"}, {30'd0, yon}, 32'd0);
        chk({tag, "_son"}, {31'd0, son}, 32'd0);
        chk({tag, "_bos_yol"}, {31'd0, bos_yol}, 32'd0);
    endtask

    // Reference: number of parent steps to a top-level node, and that node
    function automatic int hop_sayisi(input int n);
        int c = 0;
        while (n >= 3) begin
            n = (n - 3) / 4;
            c++;
        end
        return c;
    endfunction

    function automatic int kok_dugum(input int n);
        while (n >= 3) n = (n - 3) / 4;
        return n;
    endfunction

    initial begin
        int     w;
        int     tgt;
        int     node;
        int     beats;
        int     exp_beats;
        int     cyc;
        bit     done;
        bit     stalled;
        bit     rdy;
        adim_t  saved;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        idle_check("reset");
        rst_n = 1'b1;
        tick();
        idle_check("after_reset");
        cikis_hazir = 1'b1;

        // ---------------- single-hop targets ----------------
        send(8'd5);
        wait_valid(10, w);
        chk("t5_latency", w, 1);
        beat("t5_b0", 0, 2, 1, 0);
        idle_check("t5_done");

        send(8'd14);
        wait_valid(10, w);
        chk("t14_latency", w, 1);
        beat("t14_b0", 2, 3, 1, 0);
        idle_check("t14_done");

        // ---------------- three-hop target ----------------
        send(8'd100);
        chk("t100_busy_ready", {31'd0, giris_hazir}, 32'd0);
        chk("t100_busy_valid", {31'd0, cikis_gecerli}, 32'd0);
        chk("t100_busy_kaynak", {24'd0, kaynak_dugumu}, 32'd0);
        wait_valid(10, w);
        chk("t100_latency", w, 3);
        beat("t100_b0", 0, 2, 0, 0);
        beat("t100_b1", 5, 1, 0, 0);
        beat("t100_b2", 24, 1, 1, 0);
        idle_check("t100_done");

        // ---------------- four hops with backpressure on beat 2 ----------------
        send(8'd255);
        wait_valid(10, w);
        chk("t255_latency", w, 4);
        beat("t255_b0", 0, 0, 0, 0);
        cikis_hazir = 1'b0;
        repeat (3) begin
            chk("stall_valid", {31'd0, cikis_gecerli}, 32'd1);
            chk("stall_kaynak", {24'd0, kaynak_dugumu}, 32'd3);
            chk("stall_yon", {30'd0, yon}, 32'd0);
            chk("stall_son", {31'd0, son}, 32'd0);
            chk("stall_ready", {31'd0, giris_hazir}, 32'd0);
            tick();
        end
        cikis_hazir = 1'b1;
        beat("t255_b1", 3, 0, 0, 0);
        beat("t255_b2", 15, 0, 0, 0);
        chk("t255_ready_before_last", {31'd0, giris_hazir}, 32'd0);
        beat("t255_b3", 63, 0, 1, 0);
        idle_check("t255_done");

        // ---------------- zero-hop and boundary node 3 ----------------
        send(8'd1);
        wait_valid(10, w);
        chk("t1_latency", w, 0);
        beat("t1_b0", 1, 0, 1, 1);
        idle_check("t1_done");

        send(8'd3);
        wait_valid(10, w);
        chk("t3_latency", w, 1);
        beat("t3_b0", 0, 0, 1, 0);
        idle_check("t3_done");

        // ---------------- asynchronous reset during emission ----------------
        send(8'd255);
        wait_valid(10, w);
        beat("rst_b0", 0, 0, 0, 0);
        beat("rst_b1", 3, 0, 0, 0);
        chk("rst_pre_kaynak", {24'd0, kaynak_dugumu}, 32'd15);
        #1 rst_n = 1'b0;
        #1 idle_check("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            chk("rst_no_trailing", {31'd0, cikis_gecerli}, 32'd0);
            tick();
        end
        chk("rst_ready", {31'd0, giris_hazir}, 32'd1);
        send(8'd100);
        wait_valid(10, w);
        chk("post_rst_latency", w, 3);
        beat("post_rst_b0", 0, 2, 0, 0);
        beat("post_rst_b1", 5, 1, 0, 0);
        beat("post_rst_b2", 24, 1, 1, 0);
        idle_check("post_rst_done");

        // ---------------- random targets, random backpressure ----------------
        for (int r = 0; r < 40; r++) begin
            tgt = $urandom_range(0, 255);
            exp_beats = (hop_sayisi(tgt) == 0) ? 1 : hop_sayisi(tgt);
            node = kok_dugum(tgt);
            send(8'(tgt));
            beats   = 0;
            done    = 1'b0;
            cyc     = 0;
            stalled = 1'b0;
            saved   = '0;
            while (!done && cyc < 200) begin
                rdy           = 1'($urandom_range(0, 1));
                cikis_hazir   = rdy;
                giris_gecerli = 1'b1;
                hedef_dugumu  = 8'($urandom);
                chk("rnd_not_accepted", {31'd0, giris_hazir}, 32'd0);
                if (cikis_gecerli) begin
                    if (stalled) begin
                        chk("rnd_stable_kaynak", {24'd0, kaynak_dugumu}, {24'd0, saved.dugum});
                        chk("rnd_stable_yon", {30'd0, yon}, {30'd0, saved.yon});
                    end
                    if (rdy) begin
                        stalled = 1'b0;
                        if (bos_yol) begin
                            chk("rnd_zero_kaynak", {24'd0, kaynak_dugumu}, tgt);
                            chk("rnd_zero_yon", {30'd0, yon}, 32'd0);
                            node = kaynak_dugumu;
                        end else begin
                            chk("rnd_chain", {24'd0, kaynak_dugumu}, node);
                            node = 4 * int'(kaynak_dugumu) + 3 + int'(yon);
                        end
                        beats++;
                        if (son) done = 1'b1;
                    end else begin
                        stalled = 1'b1;
                        saved   = '{dugum: kaynak_dugumu, yon: yon};
                    end
                end
                tick();
                cyc++;
            end
            giris_gecerli = 1'b0;
            chk("rnd_timeout", {31'd0, done}, 32'd1);
            chk("rnd_beats", beats, exp_beats);
            chk("rnd_end_node", node, tgt);
            chk("rnd_ready_after", {31'd0, giris_hazir}, 32'd1);
        end

        cikis_hazir = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
